// File: rtl/tile_renderer.sv
// tile_renderer: five-stage tile-map / pattern-ROM / sprite-overlay pixel pipeline feeding the VGA pins.
// Build option: define TILE_SPRITE_EN to compile in the 16x16 sprite latch, hit test and overlay mux.
module tile_renderer #(
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic        clk_25m,
    input  logic        rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        valid,
    input  logic        hsync,
    input  logic        vsync,
    output logic [10:0] map_addr,
    input  logic [3:0]  map_data,
    output logic [11:0] tile_addr,
    input  logic [11:0] tile_data,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    output logic [7:0]  spr_addr,
    input  logic [11:0] spr_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    localparam int unsigned CW  = 12;
    localparam int unsigned MAW = 11;
    localparam int unsigned SAW = 8;

    typedef struct packed {
        logic [3:0] x4;
        logic [3:0] y4;
        logic       hit;
        logic [3:0] dx;
        logic [3:0] dy;
        logic       valid;
        logic       hs;
        logic       vs;
    } pix_t;

    typedef struct packed {
        logic valid;
        logic hit;
        logic hs;
        logic vs;
    } ctl_t;

    localparam pix_t PIX_RST = '{x4: 4'd0, y4: 4'd0, hit: 1'b0, dx: 4'd0, dy: 4'd0,
                                 valid: 1'b0, hs: 1'b1, vs: 1'b1};
    localparam ctl_t CTL_RST = '{valid: 1'b0, hit: 1'b0, hs: 1'b1, vs: 1'b1};

    logic [4:0]     row_c;
    logic [5:0]     col_c;
    logic [MAW-1:0] map_addr_c;
    logic           hit_c;
    logic [3:0]     dx_c;
    logic [3:0]     dy_c;
    logic [SAW-1:0] spr_addr_c;
    logic [CW-1:0]  rgb_c;
    logic [CW-1:0]  rgb;
    pix_t           s1_c, s1, s2;
    ctl_t           s3_c, s3, s4;

    // row*40 + col without a multiplier; blanked pixels read entry 0
    assign row_c      = pixel_y[8:4];
    assign col_c      = pixel_x[9:4];
    assign map_addr_c = valid ? (MAW'(row_c) << 5) + (MAW'(row_c) << 3) + MAW'(col_c) : '0;

`ifdef TILE_SPRITE_EN
    localparam int unsigned XWW = 11;
    localparam logic [9:0]  SPR_OFF = 10'h3FF;

    logic [9:0]     sx, sy;
    logic [XWW-1:0] px_w, py_w, sx_w, sy_w;

    // sprite position is sampled once per frame at the start of vertical blank
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            sx <= SPR_OFF;
            sy <= SPR_OFF;
        end else if (pixel_x == 10'd0 && pixel_y == 10'd480) begin
            sx <= sprite_x;
            sy <= sprite_y;
        end
    end

    // widened compare so a sprite near 1023 cannot wrap onto the left/top edge
    assign px_w  = XWW'(pixel_x);
    assign py_w  = XWW'(pixel_y);
    assign sx_w  = XWW'(sx);
    assign sy_w  = XWW'(sy);
    assign hit_c = valid && (px_w >= sx_w) && (px_w <= sx_w + XWW'(15))
                         && (py_w >= sy_w) && (py_w <= sy_w + XWW'(15));
    assign dx_c  = 4'(pixel_x - sx);
    assign dy_c  = 4'(pixel_y - sy);

    assign spr_addr_c = s2.hit ? {s2.dy, s2.dx} : '0;

    always_comb begin
        rgb_c = '0;
        if (s4.valid) begin
            if (s4.hit && spr_data != KEY_COLOR) rgb_c = spr_data;
            else                                 rgb_c = tile_data;
        end
    end
`else
    logic sprite_unused;

    assign hit_c      = 1'b0;
    assign dx_c       = 4'd0;
    assign dy_c       = 4'd0;
    assign spr_addr_c = '0;
    assign rgb_c      = s4.valid ? tile_data : '0;
    assign sprite_unused = ^{sprite_x, sprite_y, spr_data, pixel_y[9], KEY_COLOR,
                             s2.dx, s2.dy, s4.hit};
`endif

    always_comb begin
        s1_c       = PIX_RST;
        s1_c.x4    = pixel_x[3:0];
        s1_c.y4    = pixel_y[3:0];
        s1_c.hit   = hit_c;
        s1_c.dx    = dx_c;
        s1_c.dy    = dy_c;
        s1_c.valid = valid;
        s1_c.hs    = hsync;
        s1_c.vs    = vsync;
    end

    always_comb begin
        s3_c       = CTL_RST;
        s3_c.valid = s2.valid;
        s3_c.hit   = s2.hit;
        s3_c.hs    = s2.hs;
        s3_c.vs    = s2.vs;
    end

    // E1 map address, E3 ROM addresses, E5 colour; delay line keeps sync aligned
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            map_addr  <= '0;
            tile_addr <= '0;
            spr_addr  <= '0;
            s1        <= PIX_RST;
            s2        <= PIX_RST;
            s3        <= CTL_RST;
            s4        <= CTL_RST;
            rgb       <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            map_addr  <= map_addr_c;
            s1        <= s1_c;
            s2        <= s1;
            tile_addr <= {map_data, s2.y4, s2.x4};
            spr_addr  <= spr_addr_c;
            s3        <= s3_c;
            s4        <= s3;
            rgb       <= rgb_c;
            vga_hsync <= s4.hs;
            vga_vsync <= s4.vs;
        end
    end

    assign vga_r = rgb[11:8];
    assign vga_g = rgb[7:4];
    assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: behavioural raster/sprite model, synchronous memory models.
module tb_tile_renderer;

    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk_25m = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        valid, hsync, vsync;
    logic [10:0] map_addr;
    logic [3:0]  map_data;
    logic [11:0] tile_addr, tile_data;
    logic [9:0]  sprite_x, sprite_y;
    logic [7:0]  spr_addr;
    logic [11:0] spr_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;

    logic [3:0]  map_mem  [0:2047];
    logic [11:0] tile_rom [0:4095];
    logic [11:0] spr_rom  [0:255];

    typedef struct {
        int due;
        int map_addr;
        int tile_addr;
        int spr_addr;
        int rgb;
        bit hs;
        bit vs;
    } exp_t;

    exp_t q_map[$];
    exp_t q_tile[$];
    exp_t q_out[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int m_sx = 1023;
    int m_sy = 1023;

    tile_renderer #(.KEY_COLOR(KEY)) dut (
        .clk_25m   (clk_25m),
        .rst_n     (rst_n),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .valid     (valid),
        .hsync     (hsync),
        .vsync     (vsync),
        .map_addr  (map_addr),
        .map_data  (map_data),
        .tile_addr (tile_addr),
        .tile_data (tile_data),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .spr_addr  (spr_addr),
        .spr_data  (spr_data),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync)
    );

    initial forever #20 clk_25m = ~clk_25m;

    always @(posedge clk_25m) edge_cnt <= edge_cnt + 1;

    // external synchronous-read memories
    always @(posedge clk_25m) begin
        map_data  <= map_mem[map_addr];
        tile_data <= tile_rom[tile_addr];
        spr_data  <= spr_rom[spr_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h want %0h", name, edge_cnt, act, exp);
        end
    endtask

    // monitor: compare each expected response on the edge it is due
    always @(negedge clk_25m) begin
        exp_t e;
        while (q_map.size() > 0 && q_map[0].due <= edge_cnt) begin
            e = q_map.pop_front();
            chk("map_addr", 32'(map_addr), 32'(e.map_addr));
        end
        while (q_tile.size() > 0 && q_tile[0].due <= edge_cnt) begin
            e = q_tile.pop_front();
            chk("tile_addr", 32'(tile_addr), 32'(e.tile_addr));
            chk("spr_addr", 32'(spr_addr), 32'(e.spr_addr));
        end
        while (q_out.size() > 0 && q_out[0].due <= edge_cnt) begin
            e = q_out.pop_front();
            chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
            chk("vga_hsync", 32'(vga_hsync), 32'(e.hs));
            chk("vga_vsync", 32'(vga_vsync), 32'(e.vs));
        end
    end

    task automatic rand_inputs();
        pixel_x  = 10'($urandom_range(799));
        pixel_y  = 10'($urandom_range(524));
        valid    = 1'($urandom);
        hsync    = 1'($urandom);
        vsync    = 1'($urandom);
        sprite_x = 10'($urandom);
        sprite_y = 10'($urandom);
    endtask

    // present one raster position and push what the screen should show for it
    task automatic present(input int x, input int y);
        exp_t e;
        bit   v, hit;
        int   ma, tid, ta, sa, dx, dy, col;
        @(negedge clk_25m);
        v       = (x < 640) && (y < 480);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        valid   = v;
        hsync   = !(x >= 656 && x < 752);
        vsync   = !(y >= 490 && y < 492);
        ma  = v ? (y / 16) * 40 + (x / 16) : 0;
        tid = int'(map_mem[ma]);
        ta  = tid * 256 + (y % 16) * 16 + (x % 16);
        dx  = x - m_sx;
        dy  = y - m_sy;
        hit = 1'b0;
`ifdef TILE_SPRITE_EN
        hit = v && dx >= 0 && dx < 16 && dy >= 0 && dy < 16;
`endif
        sa = hit ? dy * 16 + dx : 0;
        if (!v)                           col = 0;
        else if (hit && spr_rom[sa] != KEY) col = int'(spr_rom[sa]);
        else                              col = int'(tile_rom[ta]);
        e.map_addr  = ma;
        e.tile_addr = ta;
        e.spr_addr  = sa;
        e.rgb       = col;
        e.hs        = !(x >= 656 && x < 752);
        e.vs        = !(y >= 490 && y < 492);
        e.due = edge_cnt + 1; q_map.push_back(e);
        e.due = edge_cnt + 3; q_tile.push_back(e);
        e.due = edge_cnt + 5; q_out.push_back(e);
        if (x == 0 && y == 480) begin
            m_sx = int'(sprite_x);
            m_sy = int'(sprite_y);
        end
    endtask

    // synchronous reset with garbage inputs; anything in flight is discarded
    task automatic do_reset(input int ncyc);
        @(negedge clk_25m);
        rst_n = 1'b0;
        q_map.delete();
        q_tile.delete();
        q_out.delete();
        rand_inputs();
        repeat (ncyc) begin
            @(negedge clk_25m);
            rand_inputs();
        end
        chk("rst_vga_r", 32'(vga_r), 32'd0);
        chk("rst_vga_g", 32'(vga_g), 32'd0);
        chk("rst_vga_b", 32'(vga_b), 32'd0);
        chk("rst_vga_hsync", 32'(vga_hsync), 32'd1);
        chk("rst_vga_vsync", 32'(vga_vsync), 32'd1);
        chk("rst_map_addr", 32'(map_addr), 32'd0);
        chk("rst_tile_addr", 32'(tile_addr), 32'd0);
        chk("rst_spr_addr", 32'(spr_addr), 32'd0);
        m_sx    = 1023;
        m_sy    = 1023;
        pixel_x = 10'd5;
        pixel_y = 10'd5;
        rst_n   = 1'b1;
    endtask

    initial begin
        int bx, by, guard, blank_idx;
        rst_n = 1'b0;
        rand_inputs();
        for (int i = 0; i < 2048; i++) map_mem[i] = 4'($urandom);
        for (int i = 0; i < 4096; i++) tile_rom[i] = 12'($urandom);
        for (int i = 0; i < 256; i++)
            spr_rom[i] = ($urandom_range(9) < 3) ? KEY : 12'($urandom);
        map_mem[42]      = 4'd5;
        tile_rom[12'h525] = 12'hABC;
        spr_rom[8'h37]   = 12'h0F0;
        spr_rom[8'h38]   = KEY;
        blank_idx = int'(map_mem[0]) * 256 + 2 * 16 + 12;
        tile_rom[blank_idx] = 12'hFFF;

        do_reset(3);

        // map address corners, tile fetch, blanking
        present(37, 18);
        present(639, 479);
        present(10, 500);
        present(700, 18);

        // end of a line through the hsync pulse, then rows through vsync
        for (int x = 600; x < 800; x++) present(x, 18);
        for (int y = 486; y < 494; y++)
            for (int x = 650; x < 670; x++) present(x, y);

        // sprite latch, key colour, miss, mid-frame move, relatch
        sprite_x = 10'd100;
        sprite_y = 10'd50;
        present(0, 480);
        present(107, 53);
        present(108, 53);
        present(116, 53);
        present(100, 50);
        present(115, 65);
        present(99, 50);
        sprite_x = 10'd300;
        present(107, 53);
        present(300, 53);
        present(0, 480);
        present(300, 53);
        present(107, 53);

        // clipping at the right/bottom edge, no wrap from far right
        sprite_x = 10'd630;
        sprite_y = 10'd470;
        present(0, 480);
        for (int x = 628; x < 650; x++) present(x, 475);
        for (int y = 476; y < 486; y++) present(635, y);
        sprite_x = 10'd1015;
        sprite_y = 10'd0;
        present(0, 480);
        for (int x = 0; x < 8; x++) present(x, 5);

        // mid-frame reset drops in-flight pixels and parks the sprite
        present(120, 60);
        present(121, 60);
        do_reset(2);
        for (int x = 0; x < 20; x++) present(x, 3);

        // randomized rounds clustered around a freshly latched sprite
        for (int r = 0; r < 8; r++) begin
            sprite_x = 10'($urandom_range(660));
            sprite_y = 10'($urandom_range(490));
            present(0, 480);
            for (int i = 0; i < 200; i++) begin
                sprite_x = 10'($urandom);
                sprite_y = 10'($urandom);
                bx = m_sx - 4 + int'($urandom_range(24));
                by = m_sy - 4 + int'($urandom_range(24));
                if (bx < 0) bx = 0;
                if (bx > 799) bx = 799;
                if (by < 0) by = 0;
                if (by > 524) by = 524;
                present(bx, by);
            end
        end

        // fully random raster positions, occasional relatch
        for (int i = 0; i < 1500; i++) begin
            sprite_x = 10'($urandom_range(700));
            sprite_y = 10'($urandom_range(500));
            if ($urandom_range(99) == 0) present(0, 480);
            else present(int'($urandom_range(799)), int'($urandom_range(524)));
        end

        guard = 0;
        while ((q_map.size() + q_tile.size() + q_out.size()) > 0 && guard < 50) begin
            @(negedge clk_25m);
            #1;
            guard++;
        end
        if ((q_map.size() + q_tile.size() + q_out.size()) > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0",
                     q_map.size() + q_tile.size() + q_out.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
